// File: rtl/writeback_pkg.sv
// Shared writeback-stage constants: datapath widths, register file size and
// result buffer geometry.
package writeback_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned REG_COUNT    = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned WB_BUF_DEPTH = 2;

  // One buffered result: {destination register, result data}.
  localparam int unsigned WB_ENTRY_W   = REG_ADDR_W + DATA_WIDTH;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding execution results awaiting retirement.
// Not fall-through: an entry pushed this cycle is visible at the head next cycle.
module wb_result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Ignore requests the buffer cannot honour so the state never corrupts.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Occupancy next-state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: buffers execution results during stalls, retires one per
// cycle into the integer register file and serves two bypassed read ports.
module writeback_stage
  import writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = writeback_pkg::DATA_WIDTH,
  parameter int unsigned REG_COUNT  = writeback_pkg::REG_COUNT,
  parameter int unsigned REG_ADDR_W = writeback_pkg::REG_ADDR_W,
  parameter int unsigned BUF_DEPTH  = writeback_pkg::WB_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uop_valid_in,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  system_stall,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  wb_full,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [31:0]           retire_count,
  output logic                  overflow_err
);

  localparam int unsigned EntryW = REG_ADDR_W + DATA_WIDTH;
  localparam int unsigned CntW   = $clog2(BUF_DEPTH + 1);

  logic [EntryW-1:0]     head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CntW-1:0]       fifo_count;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [31:0]           retire_count_q;
  logic [31:0]           retire_count_d;
  logic                  overflow_err_q;

  // Pop depends only on registered occupancy, so a push into an empty buffer
  // cannot retire in the same cycle.
  assign push = uop_valid_in & ~fifo_full;
  assign pop  = ~fifo_empty & ~system_stall;

  wb_result_fifo #(
    .WIDTH (EntryW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({rd_addr_in, result_in}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign wb_full  = (fifo_count == CntW'(BUF_DEPTH));
  assign rf_waddr = head[EntryW-1 -: REG_ADDR_W];
  assign rf_wdata = head[DATA_WIDTH-1:0];
  // Results targeting x0 still retire but never reach the array.
  assign rf_we    = pop & (rf_waddr != '0);

  assign retire_count   = retire_count_q;
  assign overflow_err   = overflow_err_q;
  assign retire_count_d = retire_count_q + {31'd0, pop};

  // Read ports: x0 hard-wired to zero, then same-cycle write bypass, then array.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (rf_we && (rf_waddr == rs1_addr)) begin
      rs1_data = rf_wdata;
    end
  end

  // Second read port, independent of the first.
  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (rf_we && (rf_waddr == rs2_addr)) begin
      rs2_data = rf_wdata;
    end
  end

  // Register array update from the retiring head entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Retirement counter (wraps naturally) and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count_q <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      retire_count_q <= retire_count_d;
      if (uop_valid_in && fifo_full) begin
        overflow_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        uop_valid_in;
  logic [31:0] result_in;
  logic [4:0]  rd_addr_in;
  logic        system_stall;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_full;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] retire_count;
  logic        overflow_err;

  int tests = 0;
  int fails = 0;

  writeback_stage dut (
    .clk          (clk),
    .reset        (reset),
    .uop_valid_in (uop_valid_in),
    .result_in    (result_in),
    .rd_addr_in   (rd_addr_in),
    .system_stall (system_stall),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .wb_full      (wb_full),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire_count (retire_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        stall;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rs1_exp;
    logic [31:0] rs2_exp;
    logic        full;
    logic [31:0] retire;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] res,
                       input logic stall, input logic [4:0] r1, input logic [4:0] r2);
    uop_valid_in = v;
    rd_addr_in   = rd;
    result_in    = res;
    system_stall = stall;
    rs1_addr     = r1;
    rs2_addr     = r2;
  endtask

  initial begin
    // valid rd res stall rs1 rs2 | we waddr wdata rs1_exp rs2_exp full retire
    vecs[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd5, 5'd0,
                1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5,
                1'b1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'd0};
    vecs[2] = '{1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd5, 5'd0,
                1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'd1};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5,
                1'b0, 5'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'd1};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0,
                1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd2};

    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset rf_we", {31'd0, rf_we}, 32'd0);
    check("reset wb_full", {31'd0, wb_full}, 32'd0);
    check("reset rs1_data", rs1_data, 32'd0);
    check("reset retire_count", retire_count, 32'd0);
    check("reset overflow_err", {31'd0, overflow_err}, 32'd0);

    // Single retire through bypass then array, and an x0 retire.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].rd, vecs[i].res, vecs[i].stall, vecs[i].rs1, vecs[i].rs2);
      #1;
      check($sformatf("vec%0d rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        check($sformatf("vec%0d rf_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].waddr});
        check($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].wdata);
      end
      check($sformatf("vec%0d rs1_data", i), rs1_data, vecs[i].rs1_exp);
      check($sformatf("vec%0d rs2_data", i), rs2_data, vecs[i].rs2_exp);
      check($sformatf("vec%0d wb_full", i), {31'd0, wb_full}, {31'd0, vecs[i].full});
      check($sformatf("vec%0d retire_count", i), retire_count, vecs[i].retire);
    end

    // Stall fill, overflow on a third valid, then in-order drain.
    @(negedge clk); drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd1, 5'd2);
    @(negedge clk); drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd1, 5'd2);
    @(negedge clk); drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd0);
    #1;
    check("fill wb_full", {31'd0, wb_full}, 32'd1);
    check("fill rf_we under stall", {31'd0, rf_we}, 32'd0);
    check("fill overflow before edge", {31'd0, overflow_err}, 32'd0);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
    #1;
    check("overflow_err set", {31'd0, overflow_err}, 32'd1);
    check("retire held by stall", retire_count, 32'd2);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
    #1;
    check("drain0 rf_we", {31'd0, rf_we}, 32'd1);
    check("drain0 rf_waddr", {27'd0, rf_waddr}, 32'd1);
    check("drain0 rf_wdata", rf_wdata, 32'h11);
    check("drain0 rs1 bypass", rs1_data, 32'h11);
    check("drain0 rs2 array", rs2_data, 32'h0);
    @(negedge clk);
    #1;
    check("drain1 rf_we", {31'd0, rf_we}, 32'd1);
    check("drain1 rf_waddr", {27'd0, rf_waddr}, 32'd2);
    check("drain1 rf_wdata", rf_wdata, 32'h22);
    check("drain1 rs1 array", rs1_data, 32'h11);
    check("drain1 rs2 bypass", rs2_data, 32'h22);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd2);
    #1;
    check("drained rf_we", {31'd0, rf_we}, 32'd0);
    check("dropped reg3", rs1_data, 32'h0);
    check("reg2 array", rs2_data, 32'h22);
    check("drained retire_count", retire_count, 32'd4);
    check("drained wb_full", {31'd0, wb_full}, 32'd0);
    check("overflow sticky", {31'd0, overflow_err}, 32'd1);

    // Concurrent push and pop with one entry resident.
    @(negedge clk); drive(1'b1, 5'd6, 32'h60, 1'b0, 5'd6, 5'd6);
    #1;
    check("conc prime rf_we", {31'd0, rf_we}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [4:0]  exp_rd;
      logic [31:0] exp_d;
      exp_rd = 5'(6 + i);
      exp_d  = (i == 0) ? 32'h60 : 32'(32'h6F + i);
      @(negedge clk);
      drive(1'b1, 5'(7 + i), 32'(32'h70 + i), 1'b0, exp_rd, exp_rd);
      #1;
      check($sformatf("conc%0d rf_we", i), {31'd0, rf_we}, 32'd1);
      check($sformatf("conc%0d rf_waddr", i), {27'd0, rf_waddr}, {27'd0, exp_rd});
      check($sformatf("conc%0d rf_wdata", i), rf_wdata, exp_d);
      check($sformatf("conc%0d rs1 bypass", i), rs1_data, exp_d);
      check($sformatf("conc%0d rs2 bypass", i), rs2_data, exp_d);
      check($sformatf("conc%0d wb_full", i), {31'd0, wb_full}, 32'd0);
    end
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 5'd0);
    #1;
    check("conc tail rf_waddr", {27'd0, rf_waddr}, 32'd10);
    check("conc tail rf_wdata", rf_wdata, 32'h73);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd10);
    #1;
    check("conc done rf_we", {31'd0, rf_we}, 32'd0);
    check("conc reg6", rs1_data, 32'h60);
    check("conc reg10", rs2_data, 32'h73);
    check("conc retire_count", retire_count, 32'd9);

    // Reset with two entries buffered under stall.
    @(negedge clk); drive(1'b1, 5'd11, 32'hAA, 1'b1, 5'd0, 5'd0);
    @(negedge clk); drive(1'b1, 5'd12, 32'hBB, 1'b1, 5'd0, 5'd0);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    #1;
    check("pre-reset wb_full", {31'd0, wb_full}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    #1;
    check("mid-reset rf_we", {31'd0, rf_we}, 32'd0);
    check("mid-reset wb_full", {31'd0, wb_full}, 32'd0);
    check("mid-reset retire_count", retire_count, 32'd0);
    check("mid-reset overflow_err", {31'd0, overflow_err}, 32'd0);
    @(negedge clk);
    #1;
    check("post-reset rf_we", {31'd0, rf_we}, 32'd0);
    for (int r = 1; r < 32; r++) begin
      rs1_addr = 5'(r);
      rs2_addr = 5'(r);
      #1;
      check($sformatf("cleared reg%0d", r), rs1_data | rs2_data, 32'h0);
    end

    // Counter wrap via backdoor preset.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd0);
    force dut.retire_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.retire_count_q;
    @(negedge clk); drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd4, 5'd0);
    #1;
    check("wrap preset", retire_count, 32'hFFFF_FFFF);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd0);
    #1;
    check("wrap rf_we", {31'd0, rf_we}, 32'd1);
    check("wrap rs1 bypass", rs1_data, 32'h44);
    @(negedge clk);
    #1;
    check("wrap retire_count", retire_count, 32'd0);
    check("wrap reg4", rs1_data, 32'h44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Consumes results from the 2-stage execution pipeline: the registered result, its valid, and the destination register index carried alongside.
- Buffers results in a small FIFO while the system is stalled, then retires one result per cycle into the 32-entry integer register file.
- Provides the register file's two combinational read ports to the decode/operand stage, with same-cycle write-through bypass.

Parameters:
- DATA_WIDTH, 32, width of result and register data (from system_param.vh).
- REG_COUNT, 32, number of architectural integer registers.
- REG_ADDR_W, 5, register index width; must equal log2(REG_COUNT).
- BUF_DEPTH, 2, result buffer entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- uop_valid_in  in  1  execution result valid; this is the execution stage's uop_valid_out.
- result_in  in  DATA_WIDTH  execution result (Execution_Result).
- rd_addr_in  in  REG_ADDR_W  destination register, cycle-aligned with result_in.
- system_stall  in  1  when high, no retirement this cycle.
- rs1_addr  in  REG_ADDR_W  read port 1 index.
- rs2_addr  in  REG_ADDR_W  read port 2 index.
- rs1_data  out  DATA_WIDTH  read port 1 data, combinational.
- rs2_data  out  DATA_WIDTH  read port 2 data, combinational.
- wb_full  out  1  buffer holds BUF_DEPTH entries; upstream must not present a valid.
- rf_we  out  1  register write occurs at the next edge.
- rf_waddr  out  REG_ADDR_W  write index; valid when rf_we is high.
- rf_wdata  out  DATA_WIDTH  write data; valid when rf_we is high.
- retire_count  out  32  number of retired results.
- overflow_err  out  1  sticky flag; valid presented while full.

Behaviour:
- Reset (synchronous): all registers and buffer storage = 0; rd/wr pointers = 0; count = 0; retire_count = 0; overflow_err = 0. Consequently rf_we = 0, wb_full = 0, rs*_data = 0.
- Push:
  - Condition: uop_valid_in & !wb_full. Writes {rd_addr_in, result_in} at wr_ptr at the edge; wr_ptr wraps modulo BUF_DEPTH.
  - uop_valid_in & wb_full: input dropped, overflow_err set to 1. It stays 1 until reset, even if a pop happens the same cycle.
- Pop:
  - Condition: pop = (count != 0) & !system_stall. Head entry retires at the edge; rd_ptr wraps.
  - Simultaneous push and pop with count between 1 and BUF_DEPTH-1: count unchanged.
  - Push into an empty buffer is never popped in the same cycle; the buffer is not fall-through.
- Latency: a valid at cycle N with an empty buffer and no stall gives rf_we=1 in cycle N+1. The register array updates at the N+1→N+2 edge. Reads see the new value in N+1 via bypass.
- wb_full = (count == BUF_DEPTH), registered-state-derived and glitch-free with respect to the inputs.
- Write port:
  - rf_waddr/rf_wdata = head entry.
  - rf_we = pop & (head rd != 0).
  - A pop with rd = 0 still retires: retire_count increments, the array is not modified, rf_we = 0.
- Register x0: reads always return 0; x0 is never written.
- Bypass: rsN_data = 0 if rsN_addr = 0; else rf_wdata if rf_we & rf_waddr == rsN_addr; else array[rsN_addr]. Both ports are independent; both may bypass in the same cycle.
- retire_count increments by 1 per pop and wraps from 0xFFFFFFFF to 0.
- system_stall held high: no pops and no retire_count increment. Pushes continue until full.
- Reset mid-operation: buffered entries are discarded without retiring; the register file clears.

Decomposition:
- Shared package (system_param.vh / new writeback_param.vh): DATA_WIDTH, REG_COUNT, REG_ADDR_W, WB_BUF_DEPTH, and an entry-width constant = REG_ADDR_W + DATA_WIDTH.
- State flops use the team's existing POS_EDGE_FF macro where applicable.
- One sub-module: wb_result_fifo, a parameterized synchronous FIFO with push/pop/full/empty/count and pointer wrap.
- Register array, bypass logic and counters live in writeback_stage.

Test Plan:
- Reset, then retire one result: valid, rd=5, result=0xDEADBEEF, no stall.
  - Cycle N+1: rf_we=1, rf_waddr=5, rs1_addr=5 gives 0xDEADBEEF via bypass.
  - N+2: array read gives 0xDEADBEEF; retire_count=1.
- x0 write: valid, rd=0, result=0x1234.
  - Retire cycle: rf_we=0, retire_count increments, rs1_addr=0 reads 0.
- Stall fill:
  - system_stall=1; push rd=1/0x11 and rd=2/0x22; wb_full=1 after the second edge.
  - A third valid (rd=3/0x33) sets overflow_err=1, and reg 3 stays 0.
  - Release the stall: regs 1 and 2 written on consecutive cycles in order; retire_count=2.
- Concurrent push and pop: with 1 entry buffered, push each cycle for 4 cycles with no stall.
  - count stays 1, wb_full never asserts, writes stay in FIFO order.
  - rs1 and rs2 both bypass the same index correctly.
- Reset mid-operation: 2 entries buffered under stall, then reset=1 for 1 cycle.
  - No write occurs; count=0, retire_count=0, overflow_err=0; all registers read 0.
- Counter wrap: force retire_count to 0xFFFFFFFF via 2^32 retires (or a bench backdoor), then one more retire → 0.
